// File: rtl/xor_keylock_ctrl.sv
// Key-gate wrapper for an XOR-locked combinational core: serial key load into a shadow
// register, atomic commit to the active key, and registered XOR gating of core I/O.
module xor_keylock_ctrl #(
    parameter int IN_W  = 36,
    parameter int OUT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_bit,
    input  logic             key_valid,
    input  logic             key_commit,
    output logic             key_err,
    output logic             locked,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             core_in_valid,
    output logic [IN_W-1:0]  core_in,
    input  logic             core_out_valid,
    input  logic [OUT_W-1:0] core_out,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       dbg_state_o
);

    localparam int KEY_W = IN_W + OUT_W;
    localparam int CNT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

    // Handshake: there is no backpressure. in_valid / core_out_valid are pure
    // pipeline tags that travel alongside their data with one cycle of latency.

    state_e             state_q;
    logic [KEY_W-1:0]   shadow_q;
    logic [KEY_W-1:0]   active_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               has_key_q;
    logic               key_err_q;
    logic               core_in_valid_q;
    logic [IN_W-1:0]    core_in_q;
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            shadow_q        <= '0;
            active_q        <= '0;
            bit_cnt_q       <= '0;
            has_key_q       <= 1'b0;
            key_err_q       <= 1'b0;
            core_in_valid_q <= 1'b0;
            core_in_q       <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
        end else begin
            // Datapath reads active_q before any commit on this edge lands,
            // so a word never sees a mix of old and new key bits.
            core_in_q       <= in_data ^ active_q[IN_W-1:0];
            core_in_valid_q <= in_valid;
            out_data_q      <= has_key_q ? (core_out ^ active_q[KEY_W-1:IN_W]) : '0;
            out_valid_q     <= core_out_valid & has_key_q;
            key_err_q       <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (key_commit) key_err_q <= 1'b1;
                    if (key_start) begin
                        state_q   <= ST_LOAD;
                        shadow_q  <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                ST_LOAD: begin
                    if (key_commit) key_err_q <= 1'b1;
                    if (key_start) begin
                        shadow_q  <= '0;
                        bit_cnt_q <= '0;
                    end else if (key_valid) begin
                        shadow_q[bit_cnt_q] <= key_bit;
                        if (bit_cnt_q == CNT_W'(KEY_W - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_ARMED;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (key_commit) begin
                        active_q  <= shadow_q;
                        has_key_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                    // A start alongside a commit still commits, then reloads.
                    if (key_start) begin
                        state_q   <= ST_LOAD;
                        shadow_q  <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign key_err       = key_err_q;
    assign locked        = ~has_key_q;
    assign core_in_valid = core_in_valid_q;
    assign core_in       = core_in_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/xor_keylock_ctrl.md
Name: xor_keylock_ctrl

Overview:
- Parametrised, clocked key-gate wrapper for XOR-locked combinational cores. Sits between primary I/O and the locked netlist.
- Loads the key serially into a shadow register and commits it atomically to an active key register.
- XORs active key bits onto the core's inputs and outputs in registered stages.
- Forces outputs to zero until a valid key has been committed.

Parameters:
- IN_W, 36, number of primary inputs carrying input key-gates.
- OUT_W, 7, number of primary outputs carrying output key-gates.
- KEY_W, IN_W+OUT_W, derived, not overridable. Key bits [IN_W-1:0] gate inputs; bits [KEY_W-1:IN_W] gate outputs.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_start  in  1  pulse; clears shadow key and bit counter, enters LOAD.
- key_bit  in  1  serial key data.
- key_valid  in  1  key_bit is sampled when high in LOAD.
- key_commit  in  1  pulse; copies shadow key to active key when ARMED.
- key_err  out  1  one-cycle pulse on an illegal commit.
- locked  out  1  high whenever no committed key exists.
- in_valid  in  1  in_data is valid.
- in_data  in  IN_W  primary inputs.
- core_in_valid  out  1  registered in_valid.
- core_in  out  IN_W  registered in_data ^ active_key[IN_W-1:0].
- core_out_valid  in  1  core_out is valid.
- core_out  in  OUT_W  locked core outputs.
- out_valid  out  1  registered core_out_valid, gated by !locked.
- out_data  out  OUT_W  registered core_out ^ active_key[KEY_W-1:IN_W]; zero while locked.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, shadow=0, active=0, bit_cnt=0, has_key=0.
  - locked=1, key_err=0, core_in_valid=0, core_in=0, out_valid=0, out_data=0.
  - Reset mid-load or mid-stream discards everything, including the committed key.
- FSM states IDLE, LOAD, ARMED:
  - IDLE --key_start--> LOAD.
  - LOAD: each key_valid cycle writes shadow[bit_cnt]=key_bit and increments bit_cnt (LSB first).
  - LOAD: when the KEY_W-th bit is sampled, bit_cnt resets to 0 and the FSM moves to ARMED the next cycle.
  - ARMED --key_commit--> IDLE. That edge sets active=shadow and has_key=1.
  - key_start in LOAD or ARMED restarts LOAD: shadow=0, bit_cnt=0.
- Extra bits and priority:
  - key_valid in IDLE or ARMED is ignored. No overflow into active.
  - key_start and key_valid in the same cycle: start wins and that bit is dropped.
- Illegal commit:
  - key_commit in IDLE or LOAD gives key_err=1 for exactly one cycle. Nothing else changes.
  - key_commit and key_start in the same cycle while ARMED: the commit occurs, then LOAD begins next cycle.
- locked = !has_key. It deasserts the cycle after a successful commit.
  - A new load while a key is active leaves active and locked unchanged until the next commit.
- Input path, 1-cycle latency, every cycle, regardless of lock:
  - core_in <= in_data ^ active[IN_W-1:0].
  - core_in_valid <= in_valid.
- Output path, 1-cycle latency:
  - out_data <= has_key ? core_out ^ active[KEY_W-1:IN_W] : 0.
  - out_valid <= core_out_valid & has_key.
- Key switchover: the commit edge is atomic. Data sampled on the commit edge uses the old key; data on the following edge uses the new key. No mixing of key bits within one word.
- No backpressure: valid is a pure pipeline tag, and data is never stalled.

Test Plan (IN_W=4, OUT_W=2, KEY_W=6):
1. Lock-out: after reset, core_out=2'b11 with core_out_valid=1 → out_data=0, out_valid=0, locked=1; in_data=4'hA → core_in=4'hA.
2. Load and commit: key_start, then shift 1,0,1,1,0,1 (LSB first), then key_commit → active=6'b101101, locked=0 next cycle. in_data=4'h0 → core_in=4'hD. core_out=2'b00 → out_data=2'b10.
3. Illegal commit: key_commit after only 3 bits → key_err high one cycle, locked stays 1. Shifting the remaining 3 bits then commit → succeeds.
4. Rekey without disruption: with key 6'b101101 active, load 6'b000000 and hold in ARMED → core_in still uses 4'hD. On commit, the word sampled on that edge uses the old key and the next word passes unmodified.
5. Extra bits and restart: shift 8 bits → bits 7–8 ignored, ARMED. key_start with key_valid=1 in the same cycle → shadow cleared, bit_cnt=0, that bit dropped.
6. Reset mid-operation: rst during LOAD with a key active → locked=1, out_data=0, active=0, core_in equals in_data.
